// File: rtl/ad9361_spi_pkg.sv
// Shared definitions for the AD9361 SPI responder: instruction field positions,
// the read-only product-ID address and the frame FSM state type.
package ad9361_spi_pkg;

    localparam int WR_BIT   = 15;
    localparam int NB_MSB   = 14;
    localparam int NB_LSB   = 12;
    localparam int ADDR_MSB = 9;

    localparam logic [9:0] ADDR_PRODUCT_ID = 10'h037;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_INSTR = 2'd1,
        ST_DATA  = 2'd2,
        ST_DONE  = 2'd3
    } spi_state_e;

endpackage

// File: rtl/spi_edge_sync.sv
// Two-flop synchronizers for the SPI pins plus edge pulses taken from the
// synchronized SCLK and CS_n copies.
module spi_edge_sync
    import ad9361_spi_pkg::*;
(
    input  logic test_clk,
    input  logic i_Rst_n,
    input  logic sclk_i,
    input  logic cs_n_i,
    input  logic mosi_i,
    output logic cs_n_o,
    output logic mosi_o,
    output logic sclk_rise_o,
    output logic sclk_fall_o,
    output logic cs_fall_o,
    output logic cs_rise_o
);

    logic [2:0] sclk_q;
    logic [2:0] cs_q;
    logic [1:0] mosi_q;

    // CS_n resets to its idle (deasserted) level so reset never creates a false frame start.
    always_ff @(posedge test_clk or negedge i_Rst_n) begin
        if (!i_Rst_n) begin
            sclk_q <= 3'b000;
            cs_q   <= 3'b111;
            mosi_q <= 2'b00;
        end else begin
            sclk_q <= {sclk_q[1:0], sclk_i};
            cs_q   <= {cs_q[1:0], cs_n_i};
            mosi_q <= {mosi_q[0], mosi_i};
        end
    end

    assign cs_n_o      = cs_q[1];
    assign mosi_o      = mosi_q[1];
    assign sclk_rise_o =  sclk_q[1] & ~sclk_q[2];
    assign sclk_fall_o = ~sclk_q[1] &  sclk_q[2];
    assign cs_fall_o   = ~cs_q[1]   &  cs_q[2];
    assign cs_rise_o   =  cs_q[1]   & ~cs_q[2];

endmodule

// File: rtl/ad9361_spi_responder.sv
// AD9361-side SPI slave serving an 8-bit register file; writes are also strobed out.
// Optional build macro SPI_RESP_STATS_EN adds good/bad frame counters.
//   state    | meaning
//   ST_IDLE  | CS_n deasserted, waiting for a frame
//   ST_INSTR | shifting in the 16-bit instruction word
//   ST_DATA  | shifting data bytes in (write) or out (read)
//   ST_DONE  | byte count exhausted, SCLK ignored until CS_n rises
module ad9361_spi_responder
    import ad9361_spi_pkg::*;
#(
    parameter int         ADDR_BITS  = 6,
    parameter logic [7:0] PRODUCT_ID = 8'h0A,
    parameter int         MAX_BYTES  = 8
) (
    input  logic       test_clk,
    input  logic       i_Rst_n,
    input  logic       i_SPI_Clk,
    input  logic       i_SPI_CS_n,
    input  logic       i_SPI_MOSI,
    output logic       o_SPI_MISO,
    output logic       o_wr_valid,
    output logic [9:0] o_wr_addr,
    output logic [7:0] o_wr_data,
    output logic       o_busy,
    output logic       o_frame_err
`ifdef SPI_RESP_STATS_EN
    ,
    output logic [15:0] o_txn_count,
    output logic [15:0] o_err_count
`endif
);

    localparam int DEPTH = 1 << ADDR_BITS;
    localparam int BCW   = $clog2(MAX_BYTES + 1);

    logic cs_n_s, mosi_s, sclk_rise, sclk_fall, cs_fall, cs_rise;

    spi_edge_sync u_sync (
        .test_clk    (test_clk),
        .i_Rst_n     (i_Rst_n),
        .sclk_i      (i_SPI_Clk),
        .cs_n_i      (i_SPI_CS_n),
        .mosi_i      (i_SPI_MOSI),
        .cs_n_o      (cs_n_s),
        .mosi_o      (mosi_s),
        .sclk_rise_o (sclk_rise),
        .sclk_fall_o (sclk_fall),
        .cs_fall_o   (cs_fall),
        .cs_rise_o   (cs_rise)
    );

    spi_state_e     state_q, state_d;
    logic [3:0]     bit_cnt_q, bit_cnt_d;
    logic [BCW-1:0] byte_cnt_q, byte_cnt_d;
    logic [14:0]    sr_q, sr_d;
    logic [9:0]     addr_q, addr_d;
    logic           is_wr_q, is_wr_d;
    logic [7:0]     tx_q, tx_d;
    logic           miso_q, miso_d;
    logic           wr_valid_q, wr_valid_d;
    logic [9:0]     wr_addr_q, wr_addr_d;
    logic [7:0]     wr_data_q, wr_data_d;
    logic           frame_err_q, frame_err_d;
    logic           mem_we, good_frame;
    logic [7:0]     mem_q [DEPTH];
    logic [15:0]    instr_w;
    logic           unused_instr;

    assign instr_w      = {sr_q, mosi_s};
    assign unused_instr = ^instr_w[11:10];

    function automatic logic in_range(input logic [9:0] a);
        return (32'(a) >> ADDR_BITS) == 32'd0;
    endfunction

    function automatic logic [7:0] rd_byte(input logic [9:0] a);
        if (!in_range(a))              return 8'h00;
        else if (a == ADDR_PRODUCT_ID) return PRODUCT_ID;
        else                           return mem_q[a[ADDR_BITS-1:0]];
    endfunction

    always_ff @(posedge test_clk or negedge i_Rst_n) begin
        if (!i_Rst_n) begin
            state_q     <= ST_IDLE;
            bit_cnt_q   <= '0;
            byte_cnt_q  <= '0;
            sr_q        <= '0;
            addr_q      <= '0;
            is_wr_q     <= 1'b0;
            tx_q        <= '0;
            miso_q      <= 1'b0;
            wr_valid_q  <= 1'b0;
            wr_addr_q   <= '0;
            wr_data_q   <= '0;
            frame_err_q <= 1'b0;
        end else begin
            state_q     <= state_d;
            bit_cnt_q   <= bit_cnt_d;
            byte_cnt_q  <= byte_cnt_d;
            sr_q        <= sr_d;
            addr_q      <= addr_d;
            is_wr_q     <= is_wr_d;
            tx_q        <= tx_d;
            miso_q      <= miso_d;
            wr_valid_q  <= wr_valid_d;
            wr_addr_q   <= wr_addr_d;
            wr_data_q   <= wr_data_d;
            frame_err_q <= frame_err_d;
        end
    end

    always_ff @(posedge test_clk or negedge i_Rst_n) begin
        if (!i_Rst_n) begin
            for (int i = 0; i < DEPTH; i++) mem_q[i] <= 8'h00;
        end else if (mem_we && in_range(wr_addr_d) && (wr_addr_d != ADDR_PRODUCT_ID)) begin
            mem_q[wr_addr_d[ADDR_BITS-1:0]] <= wr_data_d;
        end
    end

    always_comb begin
        state_d     = state_q;
        bit_cnt_d   = bit_cnt_q;
        byte_cnt_d  = byte_cnt_q;
        sr_d        = sr_q;
        addr_d      = addr_q;
        is_wr_d     = is_wr_q;
        tx_d        = tx_q;
        miso_d      = miso_q;
        wr_valid_d  = 1'b0;
        wr_addr_d   = wr_addr_q;
        wr_data_d   = wr_data_q;
        frame_err_d = 1'b0;
        mem_we      = 1'b0;
        good_frame  = 1'b0;

        case (state_q)
            ST_IDLE: begin
                miso_d = 1'b0;
                if (cs_fall) begin
                    state_d   = ST_INSTR;
                    bit_cnt_d = '0;
                end
            end
            ST_INSTR: begin
                if (sclk_rise) begin
                    sr_d      = instr_w[14:0];
                    bit_cnt_d = bit_cnt_q + 4'd1;
                    if (bit_cnt_q == 4'd15) begin
                        state_d    = ST_DATA;
                        bit_cnt_d  = '0;
                        is_wr_d    = instr_w[WR_BIT];
                        byte_cnt_d = BCW'(instr_w[NB_MSB:NB_LSB]) + BCW'(1);
                        addr_d     = instr_w[ADDR_MSB:0];
                        tx_d       = rd_byte(instr_w[ADDR_MSB:0]);
                    end
                end
            end
            ST_DATA: begin
                if (sclk_fall && !is_wr_q) begin
                    miso_d = tx_q[7];
                    tx_d   = {tx_q[6:0], 1'b0};
                end
                if (sclk_rise) begin
                    sr_d      = instr_w[14:0];
                    bit_cnt_d = bit_cnt_q + 4'd1;
                    if (bit_cnt_q == 4'd7) begin
                        bit_cnt_d  = '0;
                        addr_d     = addr_q - 10'd1;
                        byte_cnt_d = byte_cnt_q - BCW'(1);
                        if (is_wr_q) begin
                            wr_valid_d = 1'b1;
                            wr_addr_d  = addr_q;
                            wr_data_d  = instr_w[7:0];
                            mem_we     = 1'b1;
                        end else begin
                            // Next byte is fetched now so its MSB is ready for the coming fall.
                            tx_d = rd_byte(addr_q - 10'd1);
                        end
                        if (byte_cnt_q == BCW'(1)) state_d = ST_DONE;
                    end
                end
            end
            ST_DONE: miso_d = 1'b0;
            default: state_d = ST_IDLE;
        endcase

        if (cs_rise) begin
            state_d     = ST_IDLE;
            miso_d      = 1'b0;
            frame_err_d = (state_q == ST_INSTR) || ((state_q == ST_DATA) && (bit_cnt_q != 4'd0));
            good_frame  = ((state_q == ST_DATA) && (bit_cnt_q == 4'd0)) || (state_q == ST_DONE);
        end
    end

    assign o_SPI_MISO  = miso_q;
    assign o_wr_valid  = wr_valid_q;
    assign o_wr_addr   = wr_addr_q;
    assign o_wr_data   = wr_data_q;
    assign o_busy      = ~cs_n_s;
    assign o_frame_err = frame_err_q;

`ifdef SPI_RESP_STATS_EN
    logic [15:0] txn_cnt_q, err_cnt_q;

    always_ff @(posedge test_clk or negedge i_Rst_n) begin
        if (!i_Rst_n) begin
            txn_cnt_q <= '0;
            err_cnt_q <= '0;
        end else begin
            if (good_frame && (txn_cnt_q != 16'hFFFF)) txn_cnt_q <= txn_cnt_q + 16'd1;
            if (frame_err_d && (err_cnt_q != 16'hFFFF)) err_cnt_q <= err_cnt_q + 16'd1;
        end
    end

    assign o_txn_count = txn_cnt_q;
    assign o_err_count = err_cnt_q;
`else
    logic unused_good;
    assign unused_good = good_frame;
`endif

endmodule

// File: tb/tb_ad9361_spi_responder.sv
// Self-checking bench for ad9361_spi_responder: directed frames then random
// frames checked against a plain register-array model of the AD9361 rules.
module tb_ad9361_spi_responder;

    localparam int HALF = 50;
    localparam int IDLE = 200;

    logic       test_clk = 1'b0;
    logic       i_Rst_n;
    logic       i_SPI_Clk;
    logic       i_SPI_CS_n;
    logic       i_SPI_MOSI;
    logic       o_SPI_MISO;
    logic       o_wr_valid;
    logic [9:0] o_wr_addr;
    logic [7:0] o_wr_data;
    logic       o_busy;
    logic       o_frame_err;
`ifdef SPI_RESP_STATS_EN
    logic [15:0] o_txn_count;
    logic [15:0] o_err_count;
`endif

    always #5 test_clk = ~test_clk;

    ad9361_spi_responder dut (
        .test_clk    (test_clk),
        .i_Rst_n     (i_Rst_n),
        .i_SPI_Clk   (i_SPI_Clk),
        .i_SPI_CS_n  (i_SPI_CS_n),
        .i_SPI_MOSI  (i_SPI_MOSI),
        .o_SPI_MISO  (o_SPI_MISO),
        .o_wr_valid  (o_wr_valid),
        .o_wr_addr   (o_wr_addr),
        .o_wr_data   (o_wr_data),
        .o_busy      (o_busy),
        .o_frame_err (o_frame_err)
`ifdef SPI_RESP_STATS_EN
        ,
        .o_txn_count (o_txn_count),
        .o_err_count (o_err_count)
`endif
    );

    int checks = 0;
    int errors = 0;
    int good_frames = 0;
    int bad_frames = 0;
    int ferr_seen = 0;

    logic [9:0] st_addr_q [$];
    logic [7:0] st_data_q [$];
    logic [7:0] model_mem [1024];
    logic [7:0] tx_b [8];
    logic [7:0] rx_b [8];

    always @(negedge test_clk) begin
        if (o_wr_valid) begin
            st_addr_q.push_back(o_wr_addr);
            st_data_q.push_back(o_wr_data);
        end
        if (o_frame_err) ferr_seen++;
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic model_reset();
        for (int i = 0; i < 1024; i++) model_mem[i] = 8'h00;
    endtask

    // AD9361 view: 64 implemented registers, 0x037 fixed at the product ID.
    function automatic logic [7:0] exp_rd(input int a);
        if (a >= 64) return 8'h00;
        if (a == 'h037) return 8'h0A;
        return model_mem[a];
    endfunction

    task automatic spi_xfer(input logic [15:0] instr, input int nbits, input bit hold_cs);
        int k;
        i_SPI_CS_n = 1'b0;
        #HALF;
        for (int i = 0; i < nbits; i++) begin
            k = i - 16;
            if (i < 16) i_SPI_MOSI = instr[15-i];
            else        i_SPI_MOSI = tx_b[k/8][7-(k%8)];
            #HALF;
            if (i >= 16) rx_b[k/8][7-(k%8)] = o_SPI_MISO;
            i_SPI_Clk = 1'b1;
            #HALF;
            i_SPI_Clk = 1'b0;
        end
        i_SPI_MOSI = 1'b0;
        if (!hold_cs) begin
            #HALF;
            i_SPI_CS_n = 1'b1;
            #IDLE;
        end
    endtask

    task automatic do_frame(input bit wr, input int nbytes, input logic [9:0] addr, input int nbits);
        logic [15:0] instr;
        logic [9:0]  a;
        int          done_bytes;
        int          ferr0;
        bit          bad;
        instr      = {wr, 3'(nbytes - 1), 2'b00, addr};
        done_bytes = (nbits < 16) ? 0 : (nbits - 16) / 8;
        if (done_bytes > nbytes) done_bytes = nbytes;
        bad        = (nbits < 16) || (((nbits - 16) % 8) != 0);
        ferr0      = ferr_seen;
        st_addr_q.delete();
        st_data_q.delete();
        spi_xfer(instr, nbits, 1'b0);
        check("strobe_count", st_addr_q.size(), wr ? done_bytes : 0);
        for (int j = 0; j < done_bytes; j++) begin
            a = addr - 10'(j);
            if (wr) begin
                if (st_addr_q.size() > 0) begin
                    check("strobe_addr", st_addr_q.pop_front(), a);
                    check("strobe_data", st_data_q.pop_front(), tx_b[j]);
                end
                if (a < 10'd64 && a != 10'h037) model_mem[a] = tx_b[j];
            end else begin
                check("read_byte", rx_b[j], exp_rd(int'(a)));
            end
        end
        check("frame_err", ferr_seen - ferr0, bad ? 1 : 0);
        if (bad) bad_frames++;
        else     good_frames++;
    endtask

    initial begin
        int nb, cut, sel;
        logic [9:0] ad;
        bit wr;

        i_Rst_n    = 1'b0;
        i_SPI_Clk  = 1'b0;
        i_SPI_CS_n = 1'b1;
        i_SPI_MOSI = 1'b0;
        model_reset();
        #33;
        check("rst_busy", o_busy, 0);
        check("rst_miso", o_SPI_MISO, 0);
        check("rst_wr_valid", o_wr_valid, 0);
        check("rst_wr_addr", o_wr_addr, 0);
        check("rst_wr_data", o_wr_data, 0);
        check("rst_frame_err", o_frame_err, 0);
        @(negedge test_clk);
        i_Rst_n = 1'b1;
        #100;

        do_frame(1'b0, 1, 10'h037, 24);

        tx_b[0] = 8'h5C;
        do_frame(1'b1, 1, 10'h002, 24);
        do_frame(1'b0, 1, 10'h002, 24);

        tx_b[0] = 8'h11; tx_b[1] = 8'h22; tx_b[2] = 8'h33;
        do_frame(1'b1, 3, 10'h010, 40);
        do_frame(1'b0, 3, 10'h010, 40);

        do_frame(1'b0, 1, 10'h002, 10);
        do_frame(1'b0, 1, 10'h002, 24);

        tx_b[0] = 8'hFF;
        do_frame(1'b1, 1, 10'h037, 24);
        do_frame(1'b0, 1, 10'h037, 24);
        tx_b[0] = 8'hAB;
        do_frame(1'b1, 1, 10'h3FF, 24);
        do_frame(1'b0, 1, 10'h3FF, 24);

        tx_b[0] = 8'h6E; tx_b[1] = 8'h7F;
        do_frame(1'b1, 2, 10'h000, 32);
        do_frame(1'b0, 2, 10'h001, 32);

        for (int f = 0; f < 24; f++) begin
            wr  = 1'($urandom_range(0, 1));
            nb  = $urandom_range(1, 8);
            sel = $urandom_range(0, 4);
            if (sel < 3)       ad = 10'($urandom_range(0, 63));
            else if (sel == 3) ad = 10'h037;
            else               ad = 10'($urandom_range(0, 1023));
            for (int b = 0; b < 8; b++) tx_b[b] = 8'($urandom_range(0, 255));
            if ($urandom_range(0, 4) == 0) cut = 16 + 8 * $urandom_range(0, nb - 1) + $urandom_range(1, 7);
            else                           cut = 16 + 8 * nb;
            do_frame(wr, nb, ad, cut);
        end

`ifdef SPI_RESP_STATS_EN
        check("txn_count", o_txn_count, good_frames);
        check("err_count", o_err_count, bad_frames);
`endif

        tx_b[0] = 8'h99;
        do_frame(1'b1, 1, 10'h005, 24);
        spi_xfer({1'b1, 3'd0, 2'b00, 10'h005}, 20, 1'b1);
        i_Rst_n = 1'b0;
        #1;
        check("midrst_busy", o_busy, 0);
        check("midrst_miso", o_SPI_MISO, 0);
        check("midrst_wr_valid", o_wr_valid, 0);
        check("midrst_wr_addr", o_wr_addr, 0);
        check("midrst_frame_err", o_frame_err, 0);
`ifdef SPI_RESP_STATS_EN
        check("midrst_txn_count", o_txn_count, 0);
        check("midrst_err_count", o_err_count, 0);
`endif
        i_SPI_CS_n = 1'b1;
        #100;
        @(negedge test_clk);
        i_Rst_n = 1'b1;
        model_reset();
        good_frames = 0;
        bad_frames  = 0;
        #100;
        do_frame(1'b0, 1, 10'h005, 24);
        do_frame(1'b0, 1, 10'h002, 24);
        do_frame(1'b0, 1, 10'h037, 24);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/ad9361_spi_responder.md
Name: ad9361_spi_responder

Overview:
Models the AD9361 end of the 4-wire SPI link: an SPI slave that decodes 16-bit AD9361 instruction words and serves a small 8-bit register file.
- Reads return register contents on MISO.
- Writes update the register file and are also reported on a strobe interface.
- Sits on the test_clk domain. Used for on-board loopback against the SPI command master and as the simulation model in the command-path bench.

Parameters:
ADDR_BITS, 6, implemented register-file address width (2^ADDR_BITS registers).
PRODUCT_ID, 8'h0A, read-only value at address 0x037.
MAX_BYTES, 8, maximum data bytes per transaction (NB field decodes 1..8).

Ports:
test_clk  in  1  block clock; must be ≥ 8× SPI clock frequency.
i_Rst_n  in  1  asynchronous, active-low reset.
i_SPI_Clk  in  1  SPI clock from the master; idle low (mode 0), asynchronous.
i_SPI_CS_n  in  1  chip select, active low, asynchronous.
i_SPI_MOSI  in  1  serial data in, MSB first.
o_SPI_MISO  out  1  serial data out, MSB first.
o_wr_valid  out  1  one-cycle pulse per committed write byte.
o_wr_addr  out  10  address of the committed byte.
o_wr_data  out  8  data of the committed byte.
o_busy  out  1  high while CS is asserted (synchronized).
o_frame_err  out  1  one-cycle pulse on a malformed frame.

Behaviour:
- Reset: all outputs 0, FSM in IDLE. Register file is all zero except 0x037 = PRODUCT_ID.
- Input synchronization: SCLK, CS_n and MOSI each pass through 2 flip-flops. SCLK rise/fall edges are detected on the synchronized copy.
- Response latency: 3 test_clk cycles from a pin change to the response.
- Instruction word, bits 15..0:
  - [15] W/Rb: 1 = write, 0 = read.
  - [14:12] NB: byte count minus 1.
  - [11:10] ignored.
  - [9:0] start address.
- FSM states: IDLE, INSTR, DATA, DONE.
  - IDLE → INSTR on synchronized CS_n falling; bit counter cleared.
  - INSTR: sample MOSI on each SCLK rise. After the 16th bit, latch the instruction and go to DATA with byte count = NB+1. A read preloads its first byte.
  - DATA, write: after 8 sampled bits, commit the byte and pulse o_wr_valid in the cycle after the 8th rise.
  - DATA, read: shift out the preloaded byte.
  - DATA, each byte: the address decrements by 1 (AD9361 descending order), wrapping 0x000 → 0x3FF. When the byte count reaches 0, go to DONE.
  - DONE: further SCLK edges are ignored and MISO is held at 0.
  - Any state → IDLE when synchronized CS_n goes high.
- MISO:
  - Driven 0 outside DATA-read.
  - Bit 7 of a read byte is driven on the SCLK fall after the 16th instruction rise; subsequent bits change on each SCLK fall.
- Address range: addresses ≥ 2^ADDR_BITS read as 0. Writes to them are ignored in the register file but still reported on o_wr_*.
- Address 0x037 is read-only. A write to it still produces a strobe but does not change the value.
- Malformed frames: CS_n rising in INSTR, or in DATA with a partial byte, pulses o_frame_err. Any partial byte is discarded; bytes already committed remain committed.
- CS_n glitch: CS_n rising and falling again within 2 cycles is seen as two frames; no merging.
- Reset asserted mid-transaction: immediate return to the reset state, including the register file.

Optional Feature:
SPI_RESP_STATS_EN
- Defined: adds output ports o_txn_count[15:0] and o_err_count[15:0].
  - o_txn_count increments on every CS_n rise that completes without error.
  - o_err_count increments on every o_frame_err pulse.
  - Both saturate at 16'hFFFF and are cleared by reset.
- Undefined: neither port nor counter exists; behaviour is otherwise identical.

Decomposition:
Package ad9361_spi_pkg holds:
- instruction bit positions (WR_BIT = 15, NB_MSB = 14, NB_LSB = 12, ADDR_MSB = 9);
- ADDR_PRODUCT_ID = 10'h037;
- the FSM state enum.

Sub-module spi_edge_sync:
- 2-FF synchronizer for the three inputs;
- outputs synchronized levels plus sclk_rise, sclk_fall and cs_fall/cs_rise pulses.

Test Plan:
1. Reset, then read 0x037 (instruction 16'h0037, 8 more clocks) → MISO returns 8'h0A; no o_wr_valid; o_frame_err stays 0.
2. Write 0x002 = 8'h5C (instruction 16'h8002 + data) → one o_wr_valid with addr 0x002, data 8'h5C; a subsequent read of 0x002 returns 8'h5C.
3. 3-byte write at 0x010 (NB = 2, instruction 16'hA010) with data 11/22/33 → strobes at 0x010, 0x00F, 0x00E in order; a 3-byte read from 0x010 returns 11, 22, 33.
4. CS_n raised after 10 instruction bits → o_frame_err pulses once; no strobe; the next normal read succeeds.
5. Write 8'hFF to 0x037, then read it back → strobe is seen, but the read returns 8'h0A. Write 0x3FF → strobe is seen, and a read of 0x3FF returns 0.
6. Assert i_Rst_n low in the middle of a data byte → all outputs return to 0 within the same cycle and a written register reads back 0. With SPI_RESP_STATS_EN defined, the counts equal the number of good and bad frames.
